// File: rtl/game_pkg.sv
// Shared types and constants for the number-guessing game controller.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        CMP  = 3'd2,
        ADV  = 3'd3,
        DONE = 3'd4,
        FAIL = 3'd5
    } state_t;

    typedef logic [9:0] value_t;
    typedef logic [3:0] bcd_t;

    localparam logic [2:0] ROUNDS_PER_LEVEL = 3'd3;
    localparam logic [1:0] MAX_LEVEL        = 2'd3;
    localparam logic [3:0] ATTEMPTS_SAT     = 4'd15;

    function automatic logic any_digit_invalid(input bcd_t d1, input bcd_t d2, input bcd_t d3);
        return (d1 > 4'd9) || (d2 > 4'd9) || (d3 > 4'd9);
    endfunction

    // Digits in positions beyond the current level do not count towards the value.
    function automatic bcd_t mask_digit(input bcd_t d, input logic [1:0] pos, input logic [1:0] level);
        return (pos <= level) ? d : 4'd0;
    endfunction

endpackage

// File: rtl/bcd3_to_bin.sv
// Combinational three-digit BCD to 10-bit binary converter.
module bcd3_to_bin
    import game_pkg::*;
(
    input  logic [3:0] digit_1,
    input  logic [3:0] digit_2,
    input  logic [3:0] digit_3,
    output value_t     value
);

    assign value = (value_t'(digit_3) * 10'd100) + (value_t'(digit_2) * 10'd10) + value_t'(digit_1);

endmodule

// File: rtl/guess_controller.sv
// Number-guessing game controller: three levels of three rounds each.
// Define ATTEMPT_LIMIT_EN to end a round in FAIL after MAX_ATTEMPTS wrong guesses.
module guess_controller
    import game_pkg::*;
#(
    parameter int MAX_ATTEMPTS = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       submit,
    input  logic [3:0] guess_digit_1,
    input  logic [3:0] guess_digit_2,
    input  logic [3:0] guess_digit_3,
    input  logic [3:0] target_digit_1,
    input  logic [3:0] target_digit_2,
    input  logic [3:0] target_digit_3,
    output logic [1:0] Max_digit,
    output logic [2:0] round,
    output logic       too_high,
    output logic       too_low,
    output logic       correct,
    output logic       invalid,
    output logic [3:0] attempts,
    output logic       game_over,
    output logic       fail
);

    localparam logic [3:0] ATTEMPT_CAP = 4'(MAX_ATTEMPTS);
`ifdef ATTEMPT_LIMIT_EN
    localparam logic LIMIT_EN = 1'b1;
`else
    localparam logic LIMIT_EN = 1'b0;
`endif

    state_t     state_r, state_next_s;
    logic [1:0] level_r, level_next_s;
    logic [2:0] round_r, round_next_s;
    logic [3:0] attempts_r, attempts_next_s;
    logic       too_high_r, too_high_next_s;
    logic       too_low_r, too_low_next_s;
    logic       correct_r, correct_next_s;
    logic       invalid_r, invalid_next_s;
    logic       game_over_r, game_over_next_s;
    logic       fail_r, fail_next_s;
    bcd_t       g1_r, g2_r, g3_r;
    bcd_t       g1_next_s, g2_next_s, g3_next_s;

    bcd_t       gm2_s, gm3_s;
    value_t     guess_val_s, target_val_s;
    logic       guess_bad_s;
    logic [3:0] attempts_inc_s;
    logic       limit_hit_s;
    logic       restart_s;

    assign gm2_s = mask_digit(g2_r, 2'd2, level_r);
    assign gm3_s = mask_digit(g3_r, 2'd3, level_r);

    bcd3_to_bin u_guess_bin (
        .digit_1 (g1_r),
        .digit_2 (gm2_s),
        .digit_3 (gm3_s),
        .value   (guess_val_s)
    );

    bcd3_to_bin u_target_bin (
        .digit_1 (target_digit_1),
        .digit_2 (target_digit_2),
        .digit_3 (target_digit_3),
        .value   (target_val_s)
    );

    // Validity is judged on the raw latched digits, masking only affects the value.
    assign guess_bad_s    = any_digit_invalid(g1_r, g2_r, g3_r);
    assign attempts_inc_s = (attempts_r == ATTEMPTS_SAT) ? attempts_r : (attempts_r + 4'd1);
    assign limit_hit_s    = LIMIT_EN && (attempts_inc_s == ATTEMPT_CAP);
    assign restart_s      = start && ((state_r == IDLE) || (state_r == DONE) || (state_r == FAIL));

    // Next-state and next-value logic for the whole controller.
    always_comb begin
        state_next_s     = state_r;
        level_next_s     = level_r;
        round_next_s     = round_r;
        attempts_next_s  = attempts_r;
        too_high_next_s  = too_high_r;
        too_low_next_s   = too_low_r;
        correct_next_s   = correct_r;
        invalid_next_s   = invalid_r;
        game_over_next_s = game_over_r;
        fail_next_s      = fail_r;
        g1_next_s        = g1_r;
        g2_next_s        = g2_r;
        g3_next_s        = g3_r;
        if (restart_s) begin
            state_next_s     = WAIT;
            level_next_s     = 2'd1;
            round_next_s     = 3'd1;
            attempts_next_s  = 4'd0;
            too_high_next_s  = 1'b0;
            too_low_next_s   = 1'b0;
            correct_next_s   = 1'b0;
            invalid_next_s   = 1'b0;
            game_over_next_s = 1'b0;
            fail_next_s      = 1'b0;
            g1_next_s        = 4'd0;
            g2_next_s        = 4'd0;
            g3_next_s        = 4'd0;
        end else begin
            case (state_r)
                WAIT: begin
                    if (submit) begin
                        g1_next_s       = guess_digit_1;
                        g2_next_s       = guess_digit_2;
                        g3_next_s       = guess_digit_3;
                        too_high_next_s = 1'b0;
                        too_low_next_s  = 1'b0;
                        correct_next_s  = 1'b0;
                        invalid_next_s  = 1'b0;
                        state_next_s    = CMP;
                    end else begin
                        state_next_s = WAIT;
                    end
                end
                CMP: begin
                    if (guess_bad_s) begin
                        invalid_next_s = 1'b1;
                        state_next_s   = WAIT;
                    end else begin
                        attempts_next_s = attempts_inc_s;
                        if (guess_val_s == target_val_s) begin
                            correct_next_s = 1'b1;
                            state_next_s   = ADV;
                        end else begin
                            too_high_next_s = (guess_val_s > target_val_s);
                            too_low_next_s  = (guess_val_s < target_val_s);
                            if (limit_hit_s) begin
                                fail_next_s  = 1'b1;
                                state_next_s = FAIL;
                            end else begin
                                state_next_s = WAIT;
                            end
                        end
                    end
                end
                ADV: begin
                    attempts_next_s = 4'd0;
                    if (round_r < ROUNDS_PER_LEVEL) begin
                        round_next_s = round_r + 3'd1;
                        state_next_s = WAIT;
                    end else if (level_r < MAX_LEVEL) begin
                        level_next_s = level_r + 2'd1;
                        round_next_s = 3'd1;
                        state_next_s = WAIT;
                    end else begin
                        game_over_next_s = 1'b1;
                        state_next_s     = DONE;
                    end
                end
                IDLE, DONE, FAIL: begin
                    state_next_s = state_r;
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            level_r     <= 2'd1;
            round_r     <= 3'd1;
            attempts_r  <= 4'd0;
            too_high_r  <= 1'b0;
            too_low_r   <= 1'b0;
            correct_r   <= 1'b0;
            invalid_r   <= 1'b0;
            game_over_r <= 1'b0;
            fail_r      <= 1'b0;
            g1_r        <= 4'd0;
            g2_r        <= 4'd0;
            g3_r        <= 4'd0;
        end else begin
            state_r     <= state_next_s;
            level_r     <= level_next_s;
            round_r     <= round_next_s;
            attempts_r  <= attempts_next_s;
            too_high_r  <= too_high_next_s;
            too_low_r   <= too_low_next_s;
            correct_r   <= correct_next_s;
            invalid_r   <= invalid_next_s;
            game_over_r <= game_over_next_s;
            fail_r      <= fail_next_s;
            g1_r        <= g1_next_s;
            g2_r        <= g2_next_s;
            g3_r        <= g3_next_s;
        end
    end

    assign Max_digit = level_r;
    assign round     = round_r;
    assign attempts  = attempts_r;
    assign too_high  = too_high_r;
    assign too_low   = too_low_r;
    assign correct   = correct_r;
    assign invalid   = invalid_r;
    assign game_over = game_over_r;
    assign fail      = fail_r;

endmodule

// File: tb/tb_guess_controller.sv
// Self-checking bench for guess_controller against a game-rule reference model.
`timescale 1ns/1ps
module tb_guess_controller;

    logic       clk = 1'b0;
    logic       reset, start, submit;
    logic [3:0] guess_digit_1, guess_digit_2, guess_digit_3;
    logic [3:0] target_digit_1, target_digit_2, target_digit_3;
    logic [1:0] Max_digit;
    logic [2:0] round;
    logic       too_high, too_low, correct, invalid;
    logic [3:0] attempts;
    logic       game_over, fail;

    always #5 clk = ~clk;

    guess_controller #(.MAX_ATTEMPTS(7)) dut (
        .clk(clk), .reset(reset), .start(start), .submit(submit),
        .guess_digit_1(guess_digit_1), .guess_digit_2(guess_digit_2), .guess_digit_3(guess_digit_3),
        .target_digit_1(target_digit_1), .target_digit_2(target_digit_2), .target_digit_3(target_digit_3),
        .Max_digit(Max_digit), .round(round),
        .too_high(too_high), .too_low(too_low), .correct(correct), .invalid(invalid),
        .attempts(attempts), .game_over(game_over), .fail(fail)
    );

`ifdef ATTEMPT_LIMIT_EN
    localparam bit LIMIT_ON = 1'b1;
`else
    localparam bit LIMIT_ON = 1'b0;
`endif
    localparam int MAXA = 7;
    localparam int M_IDLE = 0, M_PLAY = 1, M_OVER = 2, M_FAILED = 3;

    int tests_run = 0, tests_failed = 0;

    // Reference model: game position and last-result flags.
    int m_lvl, m_rnd, m_att, m_mode;
    bit m_th, m_tl, m_co, m_inv, m_ov, m_fl;
    bit adv_pending;

    // Target lookup stage that lives beside the controller.
    function automatic int target_of(int lvl, int rnd);
        case ((lvl - 1) * 3 + (rnd - 1))
            0: return 2;   1: return 7;   2: return 4;
            3: return 57;  4: return 13;  5: return 90;
            6: return 642; 7: return 305; 8: return 999;
            default: return 0;
        endcase
    endfunction

    int tgt_now;
    assign tgt_now        = target_of(int'(Max_digit), int'(round));
    assign target_digit_1 = 4'(tgt_now % 10);
    assign target_digit_2 = 4'((tgt_now / 10) % 10);
    assign target_digit_3 = 4'(tgt_now / 100);

    logic [14:0] obs;
    assign obs = {Max_digit, round, too_high, too_low, correct, invalid, attempts, game_over, fail};

    function automatic logic [14:0] model_vec();
        return {2'(m_lvl), 3'(m_rnd), m_th, m_tl, m_co, m_inv, 4'(m_att), m_ov, m_fl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset(input int mode);
        m_lvl = 1; m_rnd = 1; m_att = 0;
        m_th = 0; m_tl = 0; m_co = 0; m_inv = 0; m_ov = 0; m_fl = 0;
        m_mode = mode;
        adv_pending = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset(M_IDLE);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (m_mode != M_PLAY) model_reset(M_PLAY);
    endtask

    // Submit a guess and wait until its result flags are due.
    task automatic play_guess(input int d3, input int d2, input int d1, input bit with_start);
        int gv, tv;
        guess_digit_3 = 4'(d3); guess_digit_2 = 4'(d2); guess_digit_1 = 4'(d1);
        submit = 1'b1;
        start  = with_start;
        tick();
        submit = 1'b0;
        start  = 1'b0;
        tick();
        if (m_mode == M_PLAY) begin
            m_th = 0; m_tl = 0; m_co = 0; m_inv = 0;
            if (d1 > 9 || d2 > 9 || d3 > 9) begin
                m_inv = 1;
            end else begin
                gv = ((m_lvl >= 3) ? d3 : 0) * 100 + ((m_lvl >= 2) ? d2 : 0) * 10 + d1;
                tv = target_of(m_lvl, m_rnd);
                m_att = (m_att < 15) ? m_att + 1 : 15;
                if (gv == tv) begin
                    m_co = 1;
                    adv_pending = 1;
                end else begin
                    if (gv > tv) m_th = 1; else m_tl = 1;
                    if (LIMIT_ON && m_att == MAXA) begin
                        m_fl = 1;
                        m_mode = M_FAILED;
                    end
                end
            end
        end
    endtask

    task automatic step_adv();
        tick();
        m_att = 0;
        if (m_rnd < 3) m_rnd = m_rnd + 1;
        else if (m_lvl < 3) begin m_lvl = m_lvl + 1; m_rnd = 1; end
        else begin m_ov = 1; m_mode = M_OVER; end
        adv_pending = 0;
    endtask

    task automatic play_correct();
        int t;
        t = target_of(m_lvl, m_rnd);
        play_guess(t / 100, (t / 10) % 10, t % 10, 1'b0);
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (obs !== model_vec() || obs !== 15'b01_001_0000_0000_0_0) begin
            tests_failed++; $display("FAIL reset_state: got %h expected %h", obs, model_vec());
        end
        play_guess(0, 0, 5, 1'b0);
        tests_run++;
        if (obs !== model_vec()) begin
            tests_failed++; $display("FAIL idle_submit_ignored: got %h expected %h", obs, model_vec());
        end
    endtask

    task automatic test_directed();
        apply_reset();
        do_start();
        tests_run++;
        if (obs !== model_vec()) begin
            tests_failed++; $display("FAIL start_init: got %h expected %h", obs, model_vec());
        end
        play_guess(0, 0, 5, 1'b0);
        tests_run++;
        if ({too_high, too_low, correct, invalid, attempts} !== 8'b1000_0001 || obs !== model_vec()) begin
            tests_failed++; $display("FAIL l1r1_too_high: got %h expected %h", obs, model_vec());
        end
        play_guess(0, 0, 2, 1'b0);
        tests_run++;
        if (correct !== 1'b1 || obs !== model_vec()) begin
            tests_failed++; $display("FAIL l1r1_correct: got %h expected %h", obs, model_vec());
        end
        step_adv();
        tests_run++;
        if (round !== 3'd2 || attempts !== 4'd0 || correct !== 1'b1 || obs !== model_vec()) begin
            tests_failed++; $display("FAIL l1r1_adv: got %h expected %h", obs, model_vec());
        end
        play_correct(); step_adv();
        play_correct(); step_adv();
        tests_run++;
        if (Max_digit !== 2'd2 || round !== 3'd1 || obs !== model_vec()) begin
            tests_failed++; $display("FAIL to_l2r1: got %h expected %h", obs, model_vec());
        end
        play_guess(3, 0, 4, 1'b0);
        tests_run++;
        if (too_low !== 1'b1 || attempts !== 4'd1 || obs !== model_vec()) begin
            tests_failed++; $display("FAIL l2r1_masked_too_low: got %h expected %h", obs, model_vec());
        end
        play_guess(0, 10, 7, 1'b0);
        tests_run++;
        if ({too_high, too_low, correct, invalid, attempts} !== 8'b0001_0001 || obs !== model_vec()) begin
            tests_failed++; $display("FAIL l2r1_invalid: got %h expected %h", obs, model_vec());
        end
        do_start();
        tests_run++;
        if (obs !== model_vec()) begin
            tests_failed++; $display("FAIL start_ignored_in_wait: got %h expected %h", obs, model_vec());
        end
        play_guess(0, 5, 7, 1'b1);
        tests_run++;
        if (correct !== 1'b1 || attempts !== 4'd2 || obs !== model_vec()) begin
            tests_failed++; $display("FAIL submit_beats_start: got %h expected %h", obs, model_vec());
        end
        step_adv();
    endtask

    task automatic test_full_game();
        apply_reset();
        do_start();
        for (int i = 0; i < 9; i++) begin
            play_correct();
            tests_run++;
            if (obs !== model_vec()) begin
                tests_failed++; $display("FAIL full_game_guess%0d: got %h expected %h", i, obs, model_vec());
            end
            step_adv();
            tests_run++;
            if (obs !== model_vec()) begin
                tests_failed++; $display("FAIL full_game_adv%0d: got %h expected %h", i, obs, model_vec());
            end
        end
        tests_run++;
        if (game_over !== 1'b1 || Max_digit !== 2'd3 || round !== 3'd3) begin
            tests_failed++; $display("FAIL game_over: got %h expected over=1 L3 R3", obs);
        end
        play_guess(0, 0, 1, 1'b0);
        tests_run++;
        if (obs !== model_vec()) begin
            tests_failed++; $display("FAIL done_submit_ignored: got %h expected %h", obs, model_vec());
        end
        do_start();
        tests_run++;
        if (obs !== 15'b01_001_0000_0000_0_0 || obs !== model_vec()) begin
            tests_failed++; $display("FAIL restart_after_done: got %h expected %h", obs, model_vec());
        end
    endtask

    task automatic test_limit();
        apply_reset();
        do_start();
        for (int i = 1; i <= 7; i++) begin
            play_guess(0, 0, 9, 1'b0);
            tests_run++;
            if (attempts !== 4'(i) || obs !== model_vec()) begin
                tests_failed++; $display("FAIL limit_guess%0d: got %h expected %h", i, obs, model_vec());
            end
        end
`ifdef ATTEMPT_LIMIT_EN
        tests_run++;
        if (fail !== 1'b1 || too_high !== 1'b1) begin
            tests_failed++; $display("FAIL limit_fail_flag: got %h expected fail=1 too_high=1", obs);
        end
        play_guess(0, 0, 2, 1'b0);
        tests_run++;
        if (attempts !== 4'd7 || fail !== 1'b1 || obs !== model_vec()) begin
            tests_failed++; $display("FAIL limit_submit_ignored: got %h expected %h", obs, model_vec());
        end
        do_start();
        tests_run++;
        if (fail !== 1'b0 || obs !== model_vec()) begin
            tests_failed++; $display("FAIL limit_restart: got %h expected %h", obs, model_vec());
        end
`else
        play_guess(0, 0, 9, 1'b0);
        tests_run++;
        if (attempts !== 4'd8 || fail !== 1'b0 || obs !== model_vec()) begin
            tests_failed++; $display("FAIL unlimited_8th: got %h expected %h", obs, model_vec());
        end
        for (int i = 9; i <= 17; i++) play_guess(0, 0, 9, 1'b0);
        tests_run++;
        if (attempts !== 4'd15 || obs !== model_vec()) begin
            tests_failed++; $display("FAIL attempts_saturate: got %h expected %h", obs, model_vec());
        end
`endif
    endtask

    task automatic test_reset_in_cmp();
        apply_reset();
        do_start();
        guess_digit_3 = 4'd0; guess_digit_2 = 4'd0; guess_digit_1 = 4'd2;
        submit = 1'b1;
        tick();
        submit = 1'b0;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
        model_reset(M_IDLE);
        tests_run++;
        if (obs !== 15'b01_001_0000_0000_0_0) begin
            tests_failed++; $display("FAIL reset_in_cmp: got %h expected %h", obs, 15'b01_001_0000_0000_0_0);
        end
        play_guess(0, 0, 2, 1'b0);
        tests_run++;
        if (obs !== model_vec()) begin
            tests_failed++; $display("FAIL idle_after_reset: got %h expected %h", obs, model_vec());
        end
        do_start();
        play_correct();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset(M_IDLE);
        tests_run++;
        if (obs !== model_vec()) begin
            tests_failed++; $display("FAIL reset_in_adv: got %h expected %h", obs, model_vec());
        end
    endtask

    task automatic test_random();
        int r, t;
        apply_reset();
        do_start();
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (m_mode != M_PLAY) begin
                do_start();
            end else if (r < 45) begin
                t = target_of(m_lvl, m_rnd);
                play_guess((m_lvl >= 3) ? t / 100 : $urandom_range(0, 9),
                           (m_lvl >= 2) ? (t / 10) % 10 : $urandom_range(0, 9),
                           t % 10, 1'b0);
            end else if (r < 85) begin
                play_guess($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                           ($urandom_range(0, 3) == 0));
            end else if (r < 93) begin
                case ($urandom_range(0, 2))
                    0: play_guess($urandom_range(10, 15), $urandom_range(0, 9), $urandom_range(0, 9), 1'b0);
                    1: play_guess($urandom_range(0, 9), $urandom_range(10, 15), $urandom_range(0, 9), 1'b0);
                    default: play_guess($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(10, 15), 1'b0);
                endcase
            end else if (r < 97) begin
                do_start();
            end else begin
                apply_reset();
            end
            tests_run++;
            if (obs !== model_vec()) begin
                tests_failed++; $display("FAIL random_step%0d: got %h expected %h", i, obs, model_vec());
            end
            if (adv_pending) begin
                step_adv();
                tests_run++;
                if (obs !== model_vec()) begin
                    tests_failed++; $display("FAIL random_adv%0d: got %h expected %h", i, obs, model_vec());
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; submit = 1'b0;
        guess_digit_1 = 4'd0; guess_digit_2 = 4'd0; guess_digit_3 = 4'd0;
        model_reset(M_IDLE);
        test_reset();
        test_directed();
        test_full_game();
        test_limit();
        test_reset_in_cmp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/guess_controller.md
GUESS_CONTROLLER -- requirements
Module: guess_controller

Interface
REQ-001 Parameter MAX_ATTEMPTS, default 7, guesses allowed per round when the attempt limit is compiled in.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; begins or restarts a game.
REQ-005 submit  input  1  one-cycle pulse; commits the current guess.
REQ-006 guess_digit_1, guess_digit_2, guess_digit_3  input  4 each  BCD guess; digit_1 is the units digit.
REQ-007 target_digit_1, target_digit_2, target_digit_3  input  4 each  BCD target from the target lookup stage, combinational in Max_digit/round.
REQ-008 Max_digit  output  2  current level (1..3), the number of significant digits.
REQ-009 round  output  3  current round within the level (1..3).
REQ-010 too_high, too_low, correct, invalid  output  1 each  result flags for the last comparison.
REQ-011 attempts  output  4  valid guesses made in the current round.
REQ-012 game_over, fail  output  1 each  game completed / attempt limit exhausted.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, CMP, ADV, DONE, FAIL.
REQ-014 IDLE: start -> WAIT with Max_digit=1, round=1, attempts=0, all flags 0.
REQ-015 WAIT: submit -> latch all three guess digits, clear all result flags, go to CMP next cycle.
REQ-016 submit SHALL be ignored in every state except WAIT; start SHALL be ignored except in IDLE, DONE, FAIL.
REQ-017 CMP (exactly one cycle): if any latched guess digit > 9 -> invalid=1, attempts unchanged, back to WAIT.
REQ-018 CMP, valid guess: attempts += 1, saturating at 15; exactly one of too_high/too_low/correct SHALL be set.
REQ-019 Comparison SHALL be numeric on 10-bit binary values d3*100+d2*10+d1.
REQ-020 Guess digits in positions above Max_digit SHALL be forced to 0 before conversion.
REQ-021 Result flags SHALL be valid 2 cycles after the accepted submit and held until the next accepted submit, start, or reset.
REQ-022 CMP next state: correct -> ADV; otherwise WAIT, except the limit case in REQ-028.
REQ-023 ADV (one cycle): attempts=0; if round<3, round+1; else if Max_digit<3, Max_digit+1 and round=1; else DONE; correct stays 1.
REQ-024 DONE: game_over=1, Max_digit=3, round=3 held; start -> WAIT with level 1, round 1, everything else cleared.
REQ-025 When start and submit coincide in WAIT, submit SHALL be taken and start ignored.

Reset
REQ-026 On reset the block SHALL enter IDLE next edge with Max_digit=1, round=1, attempts=0, and all flags, game_over, fail and latched guess = 0.
REQ-027 Reset asserted in any state, including mid-CMP or ADV, SHALL override all other inputs.

Configuration
REQ-028 With ATTEMPT_LIMIT_EN defined: a wrong valid guess making attempts == MAX_ATTEMPTS SHALL go to FAIL (fail=1, flags held); start in FAIL restarts as in REQ-024.
REQ-029 Without ATTEMPT_LIMIT_EN: attempts are unlimited; FAIL is unreachable; fail is tied to 0.

Structure
REQ-030 Package game_pkg SHALL hold the state enum, ROUNDS_PER_LEVEL=3, MAX_LEVEL=3, and the 10-bit value typedef.
REQ-031 One sub-module, bcd3_to_bin (combinational, 3 BCD digits -> 10-bit), SHALL be instantiated twice: guess and target.
REQ-032 The target lookup stage SHALL be instantiated beside this block at top level, driven by Max_digit/round; it is not inside this block.

Verification
REQ-033 Reset, start, target 2 (L1R1), guess 5 -> too_high 2 cycles after submit, attempts=1; guess 2 -> correct, ADV, round=2, attempts=0.
REQ-034 L2R1 target 57, guess digits 3,0,4 -> digit_3 masked, value 4 -> too_low; guess digits 0,10,7 -> invalid=1, attempts unchanged.
REQ-035 Play all 9 correct guesses in order -> after the ninth, game_over=1; start -> Max_digit=1, round=1, flags 0.
REQ-036 ATTEMPT_LIMIT_EN, MAX_ATTEMPTS=7: 7 wrong guesses -> fail=1, further submits ignored; without the macro, the 8th guess is accepted and attempts=8.
REQ-037 Reset asserted in the CMP cycle -> next edge IDLE, all outputs at reset values; submit in IDLE -> no effect.
